ifid_hazard_stage: RTL and testbench

//  IF/ID pipeline register plus load-use hazard control for the 5-stage MIPS32 pipeline.

---
 rtl/mips_pipe_pkg.sv | 30 +++
 rtl/load_use_detect.sv | 25 ++
 rtl/ifid_hazard_stage.sv | 136 +++++++++++++
 tb/tb_ifid_hazard_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared MIPS32 pipeline definitions: opcodes, instruction field positions,
// the NOP encoding and the IF/ID stall-controller state type.
package mips_pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_LW    = 6'h23;

  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } ifid_state_t;

  // Opcodes that read rt as a source (R-type, branches compare rs/rt, sw stores rt).
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: flags when the instruction in ID reads the register
// that a load currently in EX is about to write.
module load_use_detect
  import mips_pipe_pkg::*;
(
  input  logic [31:0] ir,
  input  logic        ir_valid,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_write_addr,
  output logic        hazard
);

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;

  assign op = ir[OP_MSB:OP_LSB];
  assign rs = ir[RS_MSB:RS_LSB];
  assign rt = ir[RT_MSB:RT_LSB];

  // $zero is never a real dependency, so a load targeting r0 is ignored.
  assign hazard = ir_valid && ex_mem_read && (ex_write_addr != 5'd0) &&
                  ((ex_write_addr == rs) || (uses_rt(op) && (ex_write_addr == rt)));

endmodule

// File: rtl/ifid_hazard_stage.sv
// IF/ID pipeline register with load-use stall FSM and branch flush.
// Optional stall/flush performance counters enabled by HAZARD_PERF_CNT_EN.
module ifid_hazard_stage
  import mips_pipe_pkg::*;
#(
  parameter int          LOAD_USE_STALLS = 1,
  parameter logic [31:0] NOP_WORD        = NOP_INSN
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] iPC,
  input  logic [31:0] iIR,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_write_addr,
  input  logic        flush,
  output logic [31:0] oPC,
  output logic [31:0] oIR,
  output logic        ovalid,
  output logic        pc_write,
  output logic        hazard_detected
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`endif
);

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_USE_STALLS - 1);

  ifid_state_t state_q, state_d;
  logic [2:0]  stall_cnt_q, stall_cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        valid_q, valid_d;
  logic        hazard;

  load_use_detect u_detect (
    .ir            (ir_q),
    .ir_valid      (valid_q),
    .ex_mem_read   (ex_mem_read),
    .ex_write_addr (ex_write_addr),
    .hazard        (hazard)
  );

  always_comb begin
    state_d         = state_q;
    stall_cnt_d     = stall_cnt_q;
    pc_d            = pc_q;
    ir_d            = ir_q;
    valid_d         = valid_q;
    pc_write        = 1'b1;
    hazard_detected = 1'b0;
    if (flush) begin
      // A redirect discards whatever was stalled; the bubble sequence ends here.
      pc_d        = iPC;
      ir_d        = NOP_WORD;
      valid_d     = 1'b0;
      state_d     = RUN;
      stall_cnt_d = 3'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (hazard) begin
            pc_write        = 1'b0;
            hazard_detected = 1'b1;
            if (LOAD_USE_STALLS > 1) begin
              state_d     = STALL;
              stall_cnt_d = STALL_RELOAD;
            end
          end else begin
            pc_d    = iPC;
            ir_d    = iIR;
            valid_d = 1'b1;
          end
        end
        STALL: begin
          pc_write        = 1'b0;
          hazard_detected = 1'b1;
          if (stall_cnt_q == 3'd1) begin
            state_d     = RUN;
            stall_cnt_d = 3'd0;
          end else begin
            stall_cnt_d = stall_cnt_q - 3'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      stall_cnt_q <= 3'd0;
      pc_q        <= 32'd0;
      ir_q        <= NOP_WORD;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      valid_q     <= valid_d;
    end
  end

  assign oPC    = pc_q;
  assign oIR    = ir_q;
  assign ovalid = valid_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_count_q, stall_count_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (hazard_detected && (stall_count_q != 32'hFFFF_FFFF)) stall_count_d = stall_count_q + 32'd1;
    if (flush && (flush_count_q != 32'hFFFF_FFFF)) flush_count_d = flush_count_q + 32'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_ifid_hazard_stage.sv
// Bench for ifid_hazard_stage: one instance with a single bubble per load-use,
// one with three, checked every cycle against a count-based reference model.
module tb_ifid_hazard_stage;

  localparam logic [31:0] ADD   = 32'h010A_4820; // add  $t1,$t0,$t2  rs=8  rt=10
  localparam logic [31:0] OR3   = 32'h018D_5825; // or   $t3,$t4,$t5  rs=12 rt=13
  localparam logic [31:0] ADDIU = 32'h2409_0005; // addiu $t1,$zero,5 rs=0  rt=9
  localparam logic [31:0] SW    = 32'hAD28_0000; // sw   $t0,0($t1)   rs=9  rt=8
  localparam logic [31:0] LWI   = 32'h8D28_0000; // lw   $t0,0($t1)   rs=9  rt=8

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] iPC, iIR;
  logic        ex_mem_read, flush;
  logic [4:0]  ex_write_addr;

  logic [31:0] o_pc [2];
  logic [31:0] o_ir [2];
  logic        o_v  [2];
  logic        o_pcw[2];
  logic        o_hd [2];
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] o_sc [2];
  logic [31:0] o_fc [2];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ifid_hazard_stage #(.LOAD_USE_STALLS(1)) u_dut1 (
    .clock(clock), .reset(reset), .iPC(iPC), .iIR(iIR),
    .ex_mem_read(ex_mem_read), .ex_write_addr(ex_write_addr), .flush(flush),
    .oPC(o_pc[0]), .oIR(o_ir[0]), .ovalid(o_v[0]), .pc_write(o_pcw[0]),
    .hazard_detected(o_hd[0])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_count(o_sc[0]), .flush_count(o_fc[0])
`endif
  );

  ifid_hazard_stage #(.LOAD_USE_STALLS(3)) u_dut3 (
    .clock(clock), .reset(reset), .iPC(iPC), .iIR(iIR),
    .ex_mem_read(ex_mem_read), .ex_write_addr(ex_write_addr), .flush(flush),
    .oPC(o_pc[1]), .oIR(o_ir[1]), .ovalid(o_v[1]), .pc_write(o_pcw[1]),
    .hazard_detected(o_hd[1])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_count(o_sc[1]), .flush_count(o_fc[1])
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Reference model: pipeline contents plus number of bubbles still owed.
  int          nst [2] = '{1, 3};
  logic [31:0] m_pc[2], m_ir[2];
  bit          m_v [2];
  int          left[2];
  longint      m_sc[2], m_fc[2];

  function automatic bit mhaz(input logic [31:0] ir, input bit v, input logic mr, input logic [4:0] wa);
    int op, rs, rt;
    bit rt_used;
    op = int'(ir[31:26]);
    rs = int'(ir[25:21]);
    rt = int'(ir[20:16]);
    rt_used = (op == 0) || (op == 4) || (op == 5) || (op == 43);
    return v && mr && (wa != 0) && ((int'(wa) == rs) || (rt_used && int'(wa) == rt));
  endfunction

  function automatic bit mhd(input int k);
    return !flush && (left[k] > 0 || mhaz(m_ir[k], m_v[k], ex_mem_read, ex_write_addr));
  endfunction

  always @(posedge clock or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_pc[k] = 0; m_ir[k] = 0; m_v[k] = 0; left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
      end else begin
        bit hz;
        hz = mhaz(m_ir[k], m_v[k], ex_mem_read, ex_write_addr);
        if (mhd(k) && m_sc[k] < 64'hFFFF_FFFF) m_sc[k]++;
        if (flush && m_fc[k] < 64'hFFFF_FFFF) m_fc[k]++;
        if (flush) begin
          m_pc[k] = iPC; m_ir[k] = 0; m_v[k] = 0; left[k] = 0;
        end else if (left[k] > 0) begin
          left[k]--;
        end else if (hz) begin
          left[k] = nst[k] - 1;
        end else begin
          m_pc[k] = iPC; m_ir[k] = iIR; m_v[k] = 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      bit hd;
      hd = mhd(k);
      chk($sformatf("d%0d_oPC", k), o_pc[k], m_pc[k]);
      chk($sformatf("d%0d_oIR", k), o_ir[k], m_ir[k]);
      chk($sformatf("d%0d_ovalid", k), 32'(o_v[k]), 32'(m_v[k]));
      chk($sformatf("d%0d_hazard", k), 32'(o_hd[k]), 32'(hd));
      chk($sformatf("d%0d_pc_write", k), 32'(o_pcw[k]), 32'(!hd));
`ifdef HAZARD_PERF_CNT_EN
      chk($sformatf("d%0d_stall_count", k), o_sc[k], 32'(m_sc[k]));
      chk($sformatf("d%0d_flush_count", k), o_fc[k], 32'(m_fc[k]));
`endif
    end
  end

  task automatic setin(input logic [31:0] pc, input logic [31:0] ir, input logic mr,
                       input logic [4:0] wa, input logic fl);
    iPC = pc; iIR = ir; ex_mem_read = mr; ex_write_addr = wa; flush = fl;
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    setin(0, 0, 0, 0, 0);
    #1;
    chk("rst_oPC", o_pc[0], 32'h0);
    chk("rst_oIR", o_ir[0], 32'h0);
    chk("rst_ovalid", 32'(o_v[0]), 32'h0);
    chk("rst_pc_write", 32'(o_pcw[0]), 32'h1);
    chk("rst_hazard", 32'(o_hd[1]), 32'h0);
    tick(); tick();
    reset = 1'b0;

    // Basic capture, then lw $t0 in EX against add using $t0 as rs
    setin(32'h4, ADD, 0, 0, 0); tick();
    chk("cap_oIR", o_ir[0], ADD);
    chk("cap_oPC", o_pc[0], 32'h4);
    setin(32'h8, OR3, 1, 8, 0); #1;
    chk("lu_hd1", 32'(o_hd[0]), 32'h1);
    chk("lu_pcw1", 32'(o_pcw[0]), 32'h0);
    chk("lu_hd3", 32'(o_hd[1]), 32'h1);
    tick();
    setin(32'h8, OR3, 0, 0, 0); #1;
    chk("lu_run1", 32'(o_hd[0]), 32'h0);
    chk("lu_held1", o_ir[0], ADD);
    chk("lu_stall3_a", 32'(o_hd[1]), 32'h1);
    chk("lu_pc3_a", o_pc[1], 32'h4);
    tick(); #1;
    chk("lu_next1", o_pc[0], 32'h8);
    chk("lu_stall3_b", 32'(o_hd[1]), 32'h1);
    chk("lu_pc3_b", o_pc[1], 32'h4);
    tick(); #1;
    chk("lu_end3", 32'(o_hd[1]), 32'h0);
    chk("lu_pc3_c", o_pc[1], 32'h4);
    tick(); #1;
    chk("lu_next3", o_pc[1], 32'h8);

    // Load into $zero, and rt of an I-type that does not read rt
    setin(32'hC, ADDIU, 0, 0, 0); tick();
    setin(32'h10, ADDIU, 1, 0, 0); #1;
    chk("zero_hd", 32'(o_hd[0]), 32'h0);
    chk("zero_pcw", 32'(o_pcw[0]), 32'h1);
    setin(32'h10, ADDIU, 1, 9, 0); #1;
    chk("irt_hd", 32'(o_hd[0]), 32'h0);
    tick();

    // sw reads rt; lw does not
    setin(32'h14, SW, 0, 0, 0); tick();
    setin(32'h18, LWI, 1, 8, 0); #1;
    chk("sw_rt_hd", 32'(o_hd[0]), 32'h1);
    tick();
    setin(32'h18, LWI, 0, 0, 0);
    tick(); tick(); tick(); tick();
    setin(32'h1C, ADD, 1, 8, 0); #1;
    chk("lw_rt_hd1", 32'(o_hd[0]), 32'h0);
    chk("lw_rt_hd3", 32'(o_hd[1]), 32'h0);

    // Flush while the 3-bubble instance is stalled
    setin(32'h20, ADD, 0, 0, 0); tick();
    setin(32'h24, OR3, 1, 8, 0); tick();
    setin(32'h40, OR3, 0, 0, 1); #1;
    chk("fl_hd_comb", 32'(o_hd[1]), 32'h0);
    chk("fl_pcw_comb", 32'(o_pcw[1]), 32'h1);
    tick(); #1;
    chk("fl_oIR", o_ir[1], 32'h0);
    chk("fl_ovalid", 32'(o_v[1]), 32'h0);
    chk("fl_oPC", o_pc[1], 32'h40);
    chk("fl_oPC1", o_pc[0], 32'h40);
    setin(32'h44, ADD, 0, 0, 0); tick(); #1;
    chk("fl_run_oIR", o_ir[1], ADD);
    chk("fl_run_oPC", o_pc[1], 32'h44);

    // Back-to-back load-use pairs
    setin(32'h48, OR3, 1, 8, 0); tick();
    setin(32'h48, OR3, 0, 0, 0); tick();
    setin(32'h4C, ADD, 1, 12, 0); #1;
    chk("b2b_hd1", 32'(o_hd[0]), 32'h1);
    tick();
    setin(32'h4C, ADD, 0, 0, 0);
    tick(); tick(); tick(); tick();

    // Reset between edges while stalled
    setin(32'h50, ADD, 0, 0, 0); tick();
    setin(32'h54, OR3, 1, 8, 0); tick();
    reset = 1'b1; #1;
    chk("mrst_oIR", o_ir[1], 32'h0);
    chk("mrst_ovalid", 32'(o_v[1]), 32'h0);
    chk("mrst_pcw", 32'(o_pcw[1]), 32'h1);
    chk("mrst_hd", 32'(o_hd[1]), 32'h0);
    chk("mrst_oPC", o_pc[1], 32'h0);
    #1 reset = 1'b0;
    setin(32'h58, ADD, 0, 0, 0); tick(); #1;
    chk("mrst_run_oPC", o_pc[1], 32'h58);
    chk("mrst_run_hd", 32'(o_hd[1]), 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
